// File: rtl/axp_lsu.sv
// axp_lsu: load/store unit for AXP memory opcodes 0A-0F and 28-2F.
// Handles one instruction at a time. IDLE accepts an instruction, REQ runs at
// most one quadword bus transaction, and RESP presents the writeback or fault.
// The LDx_L/STx_C lock covers one 16-byte granule.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready    instruction handshake; cmd/addr/mask/data latched at accept
//   mem_req/we/addr/be/wdata, mem_ack/rdata
//                         quadword bus request, held until mem_ack
//   wb_valid/ready/reg/data/fault
//                         writeback or fault, held until wb_ready
module axp_lsu #(
    parameter bit AMASK = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] cmd,
    input  logic [63:0] addr,
    input  logic [7:0]  mask,
    input  logic [63:0] data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_be,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_reg,
    output logic [63:0] wb_data,
    output logic        wb_fault
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state_q;
    logic        mem_req_q, mem_we_q, wb_valid_q, wb_fault_q;
    logic [63:0] mem_addr_q, mem_wdata_q, wb_data_q;
    logic [7:0]  mem_be_q;
    logic [4:0]  wb_reg_q;
    logic        ld_q, stc_q, ldl_q, lock_valid_q;
    logic [59:0] lock_addr_q;
    logic [2:0]  sh_q;
    logic [1:0]  ext_q;

    logic [5:0]  op;
    logic        is_ld, is_st, is_bwx, is_u, is_stc, is_ldl, illegal, misal, stc_ok;
    logic [3:0]  cnt;
    logic [2:0]  sz_m1, sh_d;
    logic [1:0]  ext_d;
    logic [63:0] r, ld_res_d;
    logic        unused_ok;

    assign unused_ok = ^cmd[20:0];

    always_comb begin
        op      = cmd[31:26];
        is_ld   = op inside {6'h0A, 6'h0B, 6'h0C, 6'h28, 6'h29, 6'h2A, 6'h2B};
        is_st   = op inside {6'h0D, 6'h0E, 6'h0F, 6'h2C, 6'h2D, 6'h2E, 6'h2F};
        is_bwx  = op inside {6'h0A, 6'h0C, 6'h0D, 6'h0E};
        is_u    = op == 6'h0B || op == 6'h0F;
        is_stc  = op == 6'h2E || op == 6'h2F;
        is_ldl  = op == 6'h2A || op == 6'h2B;
        illegal = !(is_ld || is_st) || (!AMASK && is_bwx);
        // alignment mask is access size minus one, derived from the byte mask
        cnt     = 4'($countones(mask));
        sz_m1   = 3'(cnt - 4'd1);
        // LDQ_U/STQ_U ignore the low address bits entirely
        sh_d    = is_u ? 3'd0 : addr[2:0];
        misal   = !is_u && |(addr[2:0] & sz_m1);
        stc_ok  = lock_valid_q && addr[63:4] == lock_addr_q;
        // 1: zero-extend byte, 2: zero-extend word, 3: sign-extend long, 0: quad as-is
        ext_d   = op == 6'h0A ? 2'd1 :
                  op == 6'h0C ? 2'd2 :
                  (op == 6'h28 || op == 6'h2A) ? 2'd3 : 2'd0;
        r        = mem_rdata >> {sh_q, 3'b000};
        ld_res_d = ext_q == 2'd1 ? {56'd0, r[7:0]} :
                   ext_q == 2'd2 ? {48'd0, r[15:0]} :
                   ext_q == 2'd3 ? {{32{r[31]}}, r[31:0]} : r;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            wb_valid_q   <= 1'b0;
            wb_fault_q   <= 1'b0;
            wb_reg_q     <= '0;
            wb_data_q    <= '0;
            ld_q         <= 1'b0;
            stc_q        <= 1'b0;
            ldl_q        <= 1'b0;
            sh_q         <= '0;
            ext_q        <= '0;
            lock_valid_q <= 1'b0;
            lock_addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    wb_reg_q <= cmd[25:21];
                    ld_q     <= is_ld;
                    stc_q    <= is_stc;
                    ldl_q    <= is_ldl;
                    sh_q     <= sh_d;
                    ext_q    <= ext_d;
                    // every STx_C consumes the lock, successful or not
                    if (is_stc)
                        lock_valid_q <= 1'b0;
                    if (illegal || misal) begin
                        state_q    <= RESP;
                        wb_valid_q <= 1'b1;
                        wb_fault_q <= 1'b1;
                        wb_data_q  <= '0;
                    end else if (is_stc && !stc_ok) begin
                        state_q    <= RESP;
                        wb_valid_q <= 1'b1;
                        wb_fault_q <= 1'b0;
                        wb_data_q  <= '0;
                    end else begin
                        state_q     <= REQ;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= is_st;
                        mem_addr_q  <= {addr[63:3], 3'b000};
                        mem_be_q    <= mask << sh_d;
                        mem_wdata_q <= data << {sh_d, 3'b000};
                    end
                end
                REQ: if (mem_ack) begin
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    if (ldl_q) begin
                        lock_valid_q <= 1'b1;
                        lock_addr_q  <= mem_addr_q[63:4];
                    end
                    if (ld_q || stc_q) begin
                        state_q    <= RESP;
                        wb_valid_q <= 1'b1;
                        wb_fault_q <= 1'b0;
                        wb_data_q  <= ld_q ? ld_res_d : 64'd1;
                    end else
                        state_q <= IDLE;
                end
                RESP: if (wb_ready) begin
                    state_q    <= IDLE;
                    wb_valid_q <= 1'b0;
                    wb_fault_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = state_q == IDLE;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_reg    = wb_reg_q;
    assign wb_data   = wb_data_q;
    assign wb_fault  = wb_fault_q;
endmodule

// File: doc/axp_lsu.md
# axp_lsu

Load/store unit for AXP memory opcodes 0A–0F and 28–2F. It takes the effective address and access mask from the address-calculation stage (base + displacement, mask 01/03/0F/FF) and runs one quadword-aligned bus transaction per instruction. Load data is aligned and extended before it goes to register writeback, and the unit keeps the LDx_L/STx_C lock. It sits between the address stage and the integer writeback port, and handles one instruction at a time.

## Interface
- `AMASK`, default 1: 1 enables BWX (LDBU/LDWU/STB/STW). With 0, opcodes 0A/0C/0D/0E fault as illegal.
- `clock  in  1`: sole clock, rising edge.
- `reset  in  1`: asynchronous, active-high.
- `in_valid  in  1`: an instruction is offered.
- `in_ready  out  1`: unit idle and can accept.
- `cmd  in  32`: instruction word; opcode is bits 31:26, ra is bits 25:21.
- `addr  in  64`: effective address from the address stage.
- `mask  in  8`: access-size mask from the address stage (01 byte, 03 word, 0F long, FF quad).
- `data  in  64`: store data (Ra value).
- `mem_req  out  1`: bus request.
- `mem_we  out  1`: 1 for write.
- `mem_addr  out  64`: quadword address, with bits 2:0 always 0.
- `mem_be  out  8`: byte enables.
- `mem_wdata  out  64`: write data.
- `mem_ack  in  1`: single-cycle completion, valid only while `mem_req` is high.
- `mem_rdata  in  64`: read data, valid with `mem_ack`.
- `wb_valid  out  1`: writeback or fault is pending.
- `wb_ready  in  1`: writeback consumer accepts.
- `wb_reg  out  5`: destination register (ra).
- `wb_data  out  64`: result.
- `wb_fault  out  1`: 1 means an unaligned or illegal access; `wb_data` is 0 and no register is written.

## Operation
- FSM states: IDLE, REQ, RESP.
  - `in_ready` = (state == IDLE).
  - Accept on `in_valid & in_ready`. All needed fields are latched at accept.
- Decode of the latched opcode:
  - Loads: 0A, 0B, 0C, 28, 29, 2A, 2B.
  - Stores: 0D, 0E, 0F, 2C, 2D, 2E, 2F.
  - Any other opcode is illegal: go to RESP with `wb_fault` = 1.
- Address forming:
  - LDQ_U (0B) and STQ_U (0F) clear `addr[2:0]` and never fault for alignment.
  - Every other access faults when `addr & size-1` is nonzero, where size-1 = popcount(mask)-1. On a fault, go straight to RESP with `wb_fault` = 1 and make no bus access.
  - `mem_addr` = {addr[63:3], 3'b0}.
  - `mem_be` = mask << addr[2:0] (8-bit result).
  - `mem_wdata` = data << 8·addr[2:0].
- Load result:
  - r = mem_rdata >> 8·addr[2:0].
  - LDBU: zero-extend r[7:0].
  - LDWU: zero-extend r[15:0].
  - LDL and LDL_L: sign-extend r[31:0].
  - LDQ, LDQ_L and LDQ_U: use r unchanged.
- Lock:
  - `lock_valid` and `lock_addr[63:4]` form one 16-byte granule.
  - LDx_L sets the lock on `mem_ack`.
  - STx_C succeeds only when `lock_valid` is set and `addr[63:4]` equals `lock_addr`.
    - Success: go to REQ, write, and return `wb_data` = 1.
    - Failure: go to RESP with `wb_data` = 0 and make no bus access.
  - Any STx_C clears `lock_valid`, whether it succeeds or fails.
  - Plain stores do not touch the lock.
- Transitions:
  - IDLE→REQ: accepted access that neither faults nor is a failed STx_C.
  - IDLE→RESP: fault, illegal opcode, or failed STx_C.
  - REQ→RESP on `mem_ack` for loads and STx_C.
  - REQ→IDLE on `mem_ack` for plain stores; no writeback is produced.
  - RESP→IDLE on `wb_ready`.
- Outputs are registered:
  - `mem_*` holds stable throughout REQ.
  - `wb_*` holds stable throughout RESP.
  - `wb_reg` = cmd[25:21].

## Timing
- Reset values:
  - `mem_req`, `mem_we`, `wb_valid`, `wb_fault` and `lock_valid` = 0.
  - `mem_addr`, `mem_be`, `mem_wdata`, `wb_reg` and `wb_data` = 0.
  - `in_ready` = 1 (state is IDLE).
- Accept at edge N gives `mem_req` = 1 from N+1.
- `mem_ack` sampled at edge M gives `mem_req` = 0 and `wb_valid` = 1 from M+1. Minimum accept→wb latency is 2 cycles.
- A fault or failed STx_C gives `wb_valid` from N+1 (1 cycle).
- `wb_valid` with `wb_ready` at edge K returns the unit to IDLE at K+1, so the next accept is at K+1 at the earliest. There is no overlap between instructions.
- `mem_ack` outside REQ is ignored.
- Reset during REQ or RESP:
  - `mem_req` and `wb_valid` drop immediately, without waiting for a clock.
  - The lock is cleared.
  - The transaction is lost. The bus must tolerate an abandoned request.

## Test plan
- LDBU at addr 0x1003, `mem_rdata` 0x8877665544332211 → `mem_addr` 0x1000, `mem_be` 0x08, `wb_data` 0x44.
- LDL at addr 0x2004, `mem_rdata` 0x8000000112345678 → `mem_be` 0xF0, `wb_data` 0xFFFFFFFF80000001.
- STW at addr 0x3006, `data` 0xBEEF → `mem_we` 1, `mem_be` 0xC0, `mem_wdata` 0xBEEF000000000000, `wb_valid` stays 0, `in_ready` is 1 the cycle after ack.
- LDQ at addr 0x4004 → no `mem_req`, `wb_valid` 1 with `wb_fault` 1 one cycle after accept. LDQ_U at 0x4004 → `mem_addr` 0x4000, `mem_be` 0xFF, no fault.
- LDQ_L at 0x5000, then STQ_C at 0x5008 → write issued, `wb_data` 1. A second STQ_C at 0x5008 → no `mem_req`, `wb_data` 0.
- Reset asserted while in REQ with `mem_ack` still 0 → `mem_req` 0 in the same cycle; after reset is released, `in_ready` is 1 and a following STQ_C fails with 0.
